// File: rtl/oflow_core_unit_if.sv
// Bus between the DMA feeder / register file and the tracking core.
// Carries box sets, frame/set handshakes, matching weights and the per-frame ID vector.
interface oflow_core_unit_if #(
  parameter int PE_NUM               = 24,
  parameter int MAX_BBOXES_PER_FRAME = 72,
  parameter int ID_LEN               = 12
);
  logic [85:0]       set_of_bboxes_from_dma [PE_NUM];
  logic              new_set_from_dma;
  logic              new_frame;
  logic              start;
  logic [9:0]        iou_weight;
  logic [9:0]        w_weight;
  logic [9:0]        h_weight;
  logic [9:0]        color1_weight;
  logic [9:0]        color2_weight;
  logic [9:0]        dhistory_weight;
  logic [1:0]        num_of_history_frames;
  logic [6:0]        num_of_bbox_in_frame;
  logic              ready_new_set;
  logic              ready_new_frame;
  logic              conflict_counter_th;
  logic              valid_id;
  logic              done_frame;
  logic [ID_LEN-1:0] ids [MAX_BBOXES_PER_FRAME];

  modport master (
    output set_of_bboxes_from_dma, new_set_from_dma, new_frame, start,
           iou_weight, w_weight, h_weight, color1_weight, color2_weight, dhistory_weight,
           num_of_history_frames, num_of_bbox_in_frame,
    input  ready_new_set, ready_new_frame, conflict_counter_th, valid_id, done_frame, ids
  );

  modport slave (
    input  set_of_bboxes_from_dma, new_set_from_dma, new_frame, start,
           iou_weight, w_weight, h_weight, color1_weight, color2_weight, dhistory_weight,
           num_of_history_frames, num_of_bbox_in_frame,
    output ready_new_set, ready_new_frame, conflict_counter_th, valid_id, done_frame, ids
  );
endinterface

// File: rtl/oflow_core_unit.sv
// Multi-object tracking core: each incoming box is matched against a track table by a
// weighted feature cost and receives either the matched track's ID or a fresh one.
// The table is scanned one entry per cycle per box.
module oflow_core_unit #(
  parameter int PE_NUM               = 24,
  parameter int MAX_BBOXES_PER_FRAME = 72,
  parameter int ID_LEN               = 12,
  parameter int MATCH_TH             = 64,
  parameter int CONFLICT_TH          = 4
) (
  input logic              clk,
  input logic              reset_N,
  oflow_core_unit_if.slave bus
);
  localparam int NB = MAX_BBOXES_PER_FRAME;
  localparam int EW = $clog2(NB);
  localparam int BW = $clog2(PE_NUM);
  localparam logic [31:0]   MTH = 32'(MATCH_TH);
  localparam logic [EW-1:0] CTH = EW'(CONFLICT_TH);

  typedef enum logic [2:0] {IDLE, WAIT_FRAME, LOAD, SEARCH, ASSIGN, WAIT_SET, AGE, DONE} state_t;

  function automatic logic [11:0] absd(input logic [10:0] a, input logic [10:0] b);
    return (a > b) ? {1'b0, a - b} : {1'b0, b - a};
  endfunction

  // Sum of the three per-byte absolute differences of a packed colour word.
  function automatic logic [11:0] sad3(input logic [23:0] a, input logic [23:0] b);
    logic [11:0] s;
    s = '0;
    for (int j = 0; j < 3; j++) s = s + absd({3'b0, a[8*j +: 8]}, {3'b0, b[8*j +: 8]});
    return s;
  endfunction

  function automatic logic [31:0] sat32(input logic [33:0] v);
    return (v[33:32] != 2'b00) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  state_t            state_q;
  logic [85:0]       set_q [PE_NUM];
  logic [EW-1:0]     set_base_q, total_q, entry_idx_q, best_idx_q, conf_cnt_q;
  logic [BW-1:0]     box_idx_q;
  logic [9:0]        iw_q, ww_q, hw_q, c1w_q, c2w_q, dhw_q;
  logic [1:0]        hist_q;
  logic              tv_q [NB];
  logic [85:0]       tbox_q [NB];
  logic [ID_LEN-1:0] tid_q [NB];
  logic [1:0]        tage_q [NB];
  logic              tclaim_q [NB];
  logic              tfresh_q [NB];
  logic [31:0]       best_cost_q;
  logic              best_found_q;
  logic [ID_LEN-1:0] id_ctr_q;
  logic [ID_LEN-1:0] ids_q [NB];
  logic              rdy_set_q, rdy_frame_q, conf_th_q, valid_id_q, done_frame_q;

  logic [85:0]       box_d, ent_d;
  logic [33:0]       dpos_d, acc_d;
  logic [31:0]       cost_d;
  logic              cand_d, hit_d, last_box_d, more_sets_d, free_found_d;
  logic [EW-1:0]     rem_d, nvalid_d, k_d, free_idx_d, total_in_d;
  logic [ID_LEN-1:0] nid_d;

  assign bus.ready_new_set       = rdy_set_q;
  assign bus.ready_new_frame     = rdy_frame_q;
  assign bus.conflict_counter_th = conf_th_q;
  assign bus.valid_id            = valid_id_q;
  assign bus.done_frame          = done_frame_q;
  assign bus.ids                 = ids_q;

  // Cost of the current box against the table entry being scanned, plus set bookkeeping.
  always_comb begin
    box_d  = set_q[box_idx_q];
    ent_d  = tbox_q[entry_idx_q];
    dpos_d = 34'(absd(box_d[85:75], ent_d[85:75])) + 34'(absd(box_d[74:64], ent_d[74:64]));
    acc_d  = 34'(iw_q) * dpos_d
           + 34'(ww_q)  * 34'(absd({3'b0, box_d[63:56]}, {3'b0, ent_d[63:56]}))
           + 34'(hw_q)  * 34'(absd({3'b0, box_d[55:48]}, {3'b0, ent_d[55:48]}))
           + 34'(c1w_q) * 34'(sad3(box_d[47:24], ent_d[47:24]))
           + 34'(c2w_q) * 34'(sad3(box_d[23:0], ent_d[23:0]))
           + 34'(dhw_q) * 34'(tage_q[entry_idx_q]);
    cost_d      = sat32(acc_d >> 9);
    cand_d      = tv_q[entry_idx_q] && !tfresh_q[entry_idx_q];
    hit_d       = best_found_q && (best_cost_q <= MTH);
    rem_d       = total_q - set_base_q;
    nvalid_d    = (rem_d > EW'(PE_NUM)) ? EW'(PE_NUM) : rem_d;
    last_box_d  = (EW'(box_idx_q) + EW'(1)) >= nvalid_d;
    more_sets_d = ({1'b0, set_base_q} + (EW+1)'(PE_NUM)) < {1'b0, total_q};
    k_d         = set_base_q + EW'(box_idx_q);
    nid_d       = (id_ctr_q + ID_LEN'(1) == '0) ? ID_LEN'(1) : id_ctr_q + ID_LEN'(1);
    total_in_d  = (bus.num_of_bbox_in_frame > EW'(NB)) ? EW'(NB) : EW'(bus.num_of_bbox_in_frame);
  end

  // Lowest-index free table slot for a newly created track.
  always_comb begin
    free_found_d = 1'b0;
    free_idx_d   = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (!tv_q[i]) begin
        free_found_d = 1'b1;
        free_idx_d   = EW'(i);
      end
    end
  end

  // Control FSM with the track table, ID counter and registered outputs.
  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      state_q <= IDLE;
      set_base_q <= '0; total_q <= '0; entry_idx_q <= '0; best_idx_q <= '0; conf_cnt_q <= '0;
      box_idx_q <= '0; hist_q <= '0; best_cost_q <= '0; best_found_q <= 1'b0; id_ctr_q <= '0;
      iw_q <= '0; ww_q <= '0; hw_q <= '0; c1w_q <= '0; c2w_q <= '0; dhw_q <= '0;
      rdy_set_q <= 1'b0; rdy_frame_q <= 1'b0; conf_th_q <= 1'b0; valid_id_q <= 1'b0; done_frame_q <= 1'b0;
      for (int i = 0; i < PE_NUM; i++) set_q[i] <= '0;
      for (int i = 0; i < NB; i++) begin
        tv_q[i] <= 1'b0; tbox_q[i] <= '0; tid_q[i] <= '0; tage_q[i] <= '0;
        tclaim_q[i] <= 1'b0; tfresh_q[i] <= 1'b0; ids_q[i] <= '0;
      end
    end else begin
      valid_id_q   <= 1'b0;
      done_frame_q <= 1'b0;
      if (bus.start) begin
        state_q     <= WAIT_FRAME;
        rdy_frame_q <= 1'b1;
        rdy_set_q   <= 1'b0;
        id_ctr_q    <= ID_LEN'(1);
        for (int i = 0; i < NB; i++) begin
          tv_q[i] <= 1'b0; tclaim_q[i] <= 1'b0; tfresh_q[i] <= 1'b0;
        end
      end else begin
        case (state_q)
          WAIT_FRAME: if (bus.new_frame) begin
            set_q <= bus.set_of_bboxes_from_dma;
            iw_q <= bus.iou_weight; ww_q <= bus.w_weight; hw_q <= bus.h_weight;
            c1w_q <= bus.color1_weight; c2w_q <= bus.color2_weight; dhw_q <= bus.dhistory_weight;
            hist_q <= bus.num_of_history_frames;
            total_q <= total_in_d;
            for (int i = 0; i < NB; i++) ids_q[i] <= '0;
            conf_cnt_q <= '0; conf_th_q <= 1'b0; rdy_frame_q <= 1'b0;
            set_base_q <= '0; box_idx_q <= '0;
            state_q <= (total_in_d == '0) ? AGE : LOAD;
          end
          LOAD: begin
            entry_idx_q <= '0; best_found_q <= 1'b0; best_cost_q <= '1; best_idx_q <= '0;
            state_q <= SEARCH;
          end
          SEARCH: begin
            // Strict less-than keeps the lowest index on equal cost.
            if (cand_d && (!best_found_q || cost_d < best_cost_q)) begin
              best_found_q <= 1'b1; best_cost_q <= cost_d; best_idx_q <= entry_idx_q;
            end
            if (entry_idx_q == EW'(NB - 1)) state_q <= ASSIGN;
            else entry_idx_q <= entry_idx_q + EW'(1);
          end
          ASSIGN: begin
            if (hit_d && !tclaim_q[best_idx_q]) begin
              ids_q[k_d] <= tid_q[best_idx_q];
              tbox_q[best_idx_q] <= box_d; tage_q[best_idx_q] <= '0; tclaim_q[best_idx_q] <= 1'b1;
            end else begin
              // A good match whose track is already taken this frame counts as a conflict.
              if (hit_d) begin
                conf_cnt_q <= conf_cnt_q + EW'(1);
                if (conf_cnt_q + EW'(1) >= CTH) conf_th_q <= 1'b1;
              end
              ids_q[k_d] <= id_ctr_q;
              id_ctr_q <= nid_d;
              if (free_found_d) begin
                tv_q[free_idx_d] <= 1'b1; tbox_q[free_idx_d] <= box_d; tid_q[free_idx_d] <= id_ctr_q;
                tage_q[free_idx_d] <= '0; tclaim_q[free_idx_d] <= 1'b0; tfresh_q[free_idx_d] <= 1'b1;
              end
            end
            if (!last_box_d) begin
              box_idx_q <= box_idx_q + BW'(1); state_q <= LOAD;
            end else if (more_sets_d) begin
              set_base_q <= set_base_q + EW'(PE_NUM); box_idx_q <= '0;
              rdy_set_q <= 1'b1; state_q <= WAIT_SET;
            end else begin
              state_q <= AGE;
            end
          end
          WAIT_SET: if (bus.new_set_from_dma) begin
            set_q <= bus.set_of_bboxes_from_dma; rdy_set_q <= 1'b0; state_q <= LOAD;
          end
          AGE: begin
            // Tracks created this frame were just seen, so only unseen old tracks grow older.
            for (int i = 0; i < NB; i++) begin
              if (tv_q[i] && !tclaim_q[i] && !tfresh_q[i]) begin
                if (tage_q[i] >= hist_q) tv_q[i] <= 1'b0;
                else tage_q[i] <= tage_q[i] + 2'd1;
              end
              tclaim_q[i] <= 1'b0; tfresh_q[i] <= 1'b0;
            end
            valid_id_q <= 1'b1; done_frame_q <= 1'b1; state_q <= DONE;
          end
          DONE: begin
            rdy_frame_q <= 1'b1; state_q <= WAIT_FRAME;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_oflow_core_unit.sv
// Bench for the tracking core: directed frames plus randomized frames, checked against a
// track-table model computed straight from the matching rules.
module tb_oflow_core_unit;
  localparam int PE = 24, NB = 72, IDL = 12;

  logic clk = 1'b0, reset_N = 1'b1;
  always #5 clk = ~clk;

  oflow_core_unit_if #(.PE_NUM(PE), .MAX_BBOXES_PER_FRAME(NB), .ID_LEN(IDL)) bus ();
  oflow_core_unit dut (.clk(clk), .reset_N(reset_N), .bus(bus));

  int checks = 0, errors = 0;
  int fx[128], fy[128], fw[128], fh[128], fc1[128], fc2[128];
  int wt[6];
  int hist;

  typedef struct {bit v; int x, y, w, h, c1, c2, id, age; bit cl, fr;} trk_t;
  trk_t trk[NB];
  int next_id, conf;
  int exp_ids[NB];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic longint cost_of(input int k, input int e);
    longint s1, s2, d;
    s1 = 0; s2 = 0;
    for (int j = 0; j < 3; j++) begin
      s1 += iabs(((fc1[k] >> (8*j)) & 255) - ((trk[e].c1 >> (8*j)) & 255));
      s2 += iabs(((fc2[k] >> (8*j)) & 255) - ((trk[e].c2 >> (8*j)) & 255));
    end
    d = wt[0] * (iabs(fx[k] - trk[e].x) + iabs(fy[k] - trk[e].y)) + wt[1] * iabs(fw[k] - trk[e].w)
      + wt[2] * iabs(fh[k] - trk[e].h) + wt[3] * s1 + wt[4] * s2 + wt[5] * trk[e].age;
    d = d >> 9;
    return (d > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : d;
  endfunction

  task automatic model_clear();
    for (int e = 0; e < NB; e++) begin trk[e].v = 0; trk[e].cl = 0; trk[e].fr = 0; end
    next_id = 1;
  endtask

  task automatic model_frame(input int n_in);
    int n, best, f;
    longint bc, c;
    n = (n_in > NB) ? NB : n_in;
    conf = 0;
    for (int k = 0; k < NB; k++) exp_ids[k] = 0;
    for (int k = 0; k < n; k++) begin
      best = -1; bc = 0;
      for (int e = 0; e < NB; e++)
        if (trk[e].v && !trk[e].fr) begin
          c = cost_of(k, e);
          if (best < 0 || c < bc) begin best = e; bc = c; end
        end
      if (best >= 0 && bc <= 64 && !trk[best].cl) begin
        exp_ids[k] = trk[best].id;
        trk[best].x = fx[k]; trk[best].y = fy[k]; trk[best].w = fw[k]; trk[best].h = fh[k];
        trk[best].c1 = fc1[k]; trk[best].c2 = fc2[k]; trk[best].age = 0; trk[best].cl = 1;
      end else begin
        if (best >= 0 && bc <= 64) conf++;
        exp_ids[k] = next_id;
        f = -1;
        for (int e = 0; e < NB; e++) if (!trk[e].v && f < 0) f = e;
        if (f >= 0) begin
          trk[f].v = 1; trk[f].x = fx[k]; trk[f].y = fy[k]; trk[f].w = fw[k]; trk[f].h = fh[k];
          trk[f].c1 = fc1[k]; trk[f].c2 = fc2[k]; trk[f].id = next_id; trk[f].age = 0;
          trk[f].cl = 0; trk[f].fr = 1;
        end
        next_id = (next_id == 4095) ? 1 : next_id + 1;
      end
    end
    for (int e = 0; e < NB; e++) begin
      if (trk[e].v && !trk[e].cl && !trk[e].fr) begin
        trk[e].age++;
        if (trk[e].age > hist) trk[e].v = 0;
      end
      trk[e].cl = 0; trk[e].fr = 0;
    end
  endtask

  function automatic logic [85:0] pk(input int k);
    return {11'(fx[k]), 11'(fy[k]), 8'(fw[k]), 8'(fh[k]), 24'(fc1[k]), 24'(fc2[k])};
  endfunction

  task automatic drive_set(input int s, input int n);
    for (int i = 0; i < PE; i++) begin
      if (s * PE + i < n) bus.set_of_bboxes_from_dma[i] = pk(s * PE + i);
      else bus.set_of_bboxes_from_dma[i] = {22'($urandom), $urandom, $urandom};
    end
  endtask

  task automatic junk_cfg();
    bus.iou_weight = 10'($urandom); bus.w_weight = 10'($urandom); bus.h_weight = 10'($urandom);
    bus.color1_weight = 10'($urandom); bus.color2_weight = 10'($urandom);
    bus.dhistory_weight = 10'($urandom); bus.num_of_history_frames = 2'($urandom);
    bus.num_of_bbox_in_frame = 7'($urandom);
  endtask

  task automatic do_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    chk("start_rdy_frame", 64'(bus.ready_new_frame), 64'd1);
    model_clear();
  endtask

  task automatic run_frame(input int n_in, input string tag);
    int n, cyc;
    n = (n_in > NB) ? NB : n_in;
    cyc = 0;
    while (bus.ready_new_frame !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    chk({tag, "_rdy_frame"}, 64'(bus.ready_new_frame), 64'd1);
    drive_set(0, n);
    bus.iou_weight = 10'(wt[0]); bus.w_weight = 10'(wt[1]); bus.h_weight = 10'(wt[2]);
    bus.color1_weight = 10'(wt[3]); bus.color2_weight = 10'(wt[4]); bus.dhistory_weight = 10'(wt[5]);
    bus.num_of_history_frames = 2'(hist); bus.num_of_bbox_in_frame = 7'(n_in);
    bus.new_frame = 1'b1;
    @(negedge clk); bus.new_frame = 1'b0;
    junk_cfg();
    chk({tag, "_rdy_frame_low"}, 64'(bus.ready_new_frame), 64'd0);
    model_frame(n_in);
    for (int s = 1; s * PE < n; s++) begin
      cyc = 0;
      while (bus.ready_new_set !== 1'b1 && cyc < 3000) begin @(negedge clk); cyc++; end
      chk($sformatf("%s_rset_rise%0d", tag, s), 64'(bus.ready_new_set), 64'd1);
      chk($sformatf("%s_rframe_in_set%0d", tag, s), 64'(bus.ready_new_frame), 64'd0);
      bus.new_frame = 1'b1;
      @(negedge clk); bus.new_frame = 1'b0;
      drive_set(s, n);
      bus.new_set_from_dma = 1'b1;
      @(negedge clk); bus.new_set_from_dma = 1'b0;
      chk($sformatf("%s_rset_fall%0d", tag, s), 64'(bus.ready_new_set), 64'd0);
    end
    cyc = 0;
    while (bus.valid_id !== 1'b1 && cyc < 6000) begin @(negedge clk); cyc++; end
    chk({tag, "_valid_id"}, 64'(bus.valid_id), 64'd1);
    chk({tag, "_done_frame"}, 64'(bus.done_frame), 64'd1);
    chk({tag, "_rframe_at_done"}, 64'(bus.ready_new_frame), 64'd0);
    chk({tag, "_conf_th"}, 64'(bus.conflict_counter_th), 64'(conf >= 4));
    for (int k = 0; k < NB; k++) chk($sformatf("%s_id[%0d]", tag, k), 64'(bus.ids[k]), 64'(exp_ids[k]));
    @(negedge clk);
    chk({tag, "_valid_pulse"}, 64'(bus.valid_id), 64'd0);
    chk({tag, "_done_pulse"}, 64'(bus.done_frame), 64'd0);
    chk({tag, "_rframe_after"}, 64'(bus.ready_new_frame), 64'd1);
  endtask

  task automatic frame_a();
    for (int k = 0; k < PE; k++) begin
      fx[k] = 12; fy[k] = 60 + k; fw[k] = 20; fh[k] = 40; fc1[k] = 24'h102030; fc2[k] = 24'h405060;
    end
  endtask

  task automatic gen_rand(input int n);
    int e;
    for (int k = 0; k < n; k++) begin
      e = $urandom_range(0, NB - 1);
      if ($urandom_range(0, 3) != 0 && trk[e].v) begin
        fx[k] = (trk[e].x + $urandom_range(0, 4) - 2) & 2047;
        fy[k] = (trk[e].y + $urandom_range(0, 4) - 2) & 2047;
        fw[k] = (trk[e].w + $urandom_range(0, 1)) & 255;
        fh[k] = trk[e].h;
        fc1[k] = trk[e].c1 ^ $urandom_range(0, 1); fc2[k] = trk[e].c2;
      end else begin
        fx[k] = $urandom_range(0, 2047); fy[k] = $urandom_range(0, 2047);
        fw[k] = $urandom_range(0, 255); fh[k] = $urandom_range(0, 255);
        fc1[k] = $urandom_range(0, 24'hFFFFFF); fc2[k] = $urandom_range(0, 24'hFFFFFF);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    logic any;
    any = bus.ready_new_set | bus.ready_new_frame | bus.valid_id | bus.done_frame | bus.conflict_counter_th;
    for (int k = 0; k < NB; k++) any = any | (|bus.ids[k]);
    chk(tag, 64'(any), 64'd0);
  endtask

  initial begin
    int cyc, seen;
    int cnts[6] = '{7, 72, 100, 45, 0, 30};
    bus.new_set_from_dma = 1'b0; bus.new_frame = 1'b0; bus.start = 1'b0;
    junk_cfg();
    drive_set(0, 0);
    wt = '{512, 128, 128, 85, 85, 85};
    hist = 3;
    model_clear();

    // Reset state and start handshake
    repeat (3) @(negedge clk);
    chk_all_zero("reset_outputs");
    reset_N = 1'b0;
    @(negedge clk);
    chk_all_zero("idle_outputs");
    do_start();

    // Frame of 24 distinct boxes, then the same frame again
    frame_a();
    run_frame(24, "t1");
    chk("t1_id0_const", 64'(bus.ids[0]), 64'd1);
    chk("t1_id23_const", 64'(bus.ids[23]), 64'd24);
    chk("t1_id24_const", 64'(bus.ids[24]), 64'd0);
    run_frame(24, "t2");
    chk("t2_id23_const", 64'(bus.ids[23]), 64'd24);
    chk("t2_conf_const", 64'(bus.conflict_counter_th), 64'd0);

    // Full 72-box frame over three sets
    gen_rand(72);
    for (int k = 0; k < 72; k++) begin fx[k] = $urandom_range(0, 2047); fy[k] = $urandom_range(0, 2047); end
    run_frame(72, "t3");

    // Two and then five identical boxes against one track
    do_start();
    fx[0] = 300; fy[0] = 400; fw[0] = 30; fh[0] = 50; fc1[0] = 24'hAABBCC; fc2[0] = 24'h112233;
    for (int k = 1; k < 5; k++) begin
      fx[k] = fx[0]; fy[k] = fy[0]; fw[k] = fw[0]; fh[k] = fh[0]; fc1[k] = fc1[0]; fc2[k] = fc2[0];
    end
    run_frame(1, "t5a");
    run_frame(2, "t5b");
    chk("t5_first_keeps", 64'(bus.ids[0]), 64'd1);
    chk("t5_second_new", 64'(bus.ids[1]), 64'd2);
    chk("t5_th_low", 64'(bus.conflict_counter_th), 64'd0);
    run_frame(5, "t5c");
    chk("t5_th_high", 64'(bus.conflict_counter_th), 64'd1);

    // Track survives 3 empty frames but is dropped after 4
    do_start();
    hist = 3;
    fx[0] = 1000; fy[0] = 900; fw[0] = 16; fh[0] = 16; fc1[0] = 24'h808080; fc2[0] = 24'h010203;
    run_frame(1, "t4a");
    for (int i = 0; i < 3; i++) run_frame(0, $sformatf("t4e%0d", i));
    run_frame(1, "t4b");
    chk("t4_survives", 64'(bus.ids[0]), 64'd1);
    for (int i = 0; i < 4; i++) run_frame(0, $sformatf("t4f%0d", i));
    run_frame(1, "t4c");
    chk("t4_dropped", 64'(bus.ids[0]), 64'd2);

    // Randomized frames with random weights and history depth
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 6; i++) wt[i] = $urandom_range(0, 1023);
      hist = $urandom_range(0, 3);
      gen_rand(cnts[f] > NB ? NB : cnts[f]);
      run_frame(cnts[f], $sformatf("r%0d", f));
    end

    // Reset during SEARCH, then new_frame without start must be ignored
    wt = '{512, 128, 128, 85, 85, 85};
    hist = 3;
    frame_a();
    drive_set(0, 24);
    bus.num_of_bbox_in_frame = 7'd24;
    bus.new_frame = 1'b1;
    @(negedge clk); bus.new_frame = 1'b0;
    repeat (40) @(negedge clk);
    reset_N = 1'b1;
    #1;
    chk_all_zero("t6_reset_async");
    @(negedge clk);
    chk_all_zero("t6_reset_held");
    reset_N = 1'b0;
    @(negedge clk);
    bus.new_frame = 1'b1;
    @(negedge clk); bus.new_frame = 1'b0;
    seen = 0;
    for (cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (bus.valid_id === 1'b1 || bus.ready_new_set === 1'b1) seen = 1;
    end
    chk("t6_ignored_frame", 64'(seen), 64'd0);
    chk("t6_rdy_frame_low", 64'(bus.ready_new_frame), 64'd0);
    do_start();
    run_frame(24, "t6");
    chk("t6_id0_const", 64'(bus.ids[0]), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
